// File: rtl/mul_cpa_pipe.sv
// mul_cpa_pipe: segmented pipelined carry-propagate adder resolving Wallace-tree carry/sum vectors
//   clock, reset_n        rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready     input handshake; in_cout (weight 2^(j+1)), in_sout (weight 2^j), in_tag sideband
//   out_valid/out_ready   output handshake; out_sum, out_carry (overflow past bit DATA_WIDTH-1), out_tag
module mul_cpa_pipe #(
  parameter int DATA_WIDTH = 128,
  parameter int SEG_WIDTH  = 32,
  parameter int TAG_WIDTH  = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_cout,
  input  logic [DATA_WIDTH-1:0] in_sout,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_sum,
  output logic                  out_carry,
  output logic [TAG_WIDTH-1:0]  out_tag
);
  localparam int NSEG = DATA_WIDTH / SEG_WIDTH;
  logic [NSEG-1:0][DATA_WIDTH-1:0] res_q, res_d, b_q, a_s, b_s;
  logic [NSEG-1:0][SEG_WIDTH-1:0]  seg_s;
  logic [NSEG-1:0][TAG_WIDTH-1:0]  tag_q, tag_d;
  logic [NSEG-1:0]                 vld_q, vld_d, cy_q, cy_d, ci_s;
  logic                            advance;
  logic                            unused;
  // The top carry bit would weigh 2^DATA_WIDTH and the last stage's B copy has no consumer.
  assign unused    = in_cout[DATA_WIDTH-1] ^ (^b_q[NSEG-1]);
  assign advance   = !vld_q[NSEG-1] | out_ready;
  assign in_ready  = advance;
  assign out_valid = vld_q[NSEG-1];
  assign out_sum   = res_q[NSEG-1];
  assign out_carry = cy_q[NSEG-1];
  assign out_tag   = tag_q[NSEG-1];
  // Stage k adds segment k; res carries resolved low segments and still-unresolved high A segments.
  always_comb begin
    for (int k = 0; k < NSEG; k++) begin
      a_s[k]   = (k == 0) ? in_sout : res_q[(k == 0) ? 0 : k - 1];
      b_s[k]   = (k == 0) ? {in_cout[DATA_WIDTH-2:0], 1'b0} : b_q[(k == 0) ? 0 : k - 1];
      ci_s[k]  = (k == 0) ? 1'b0 : cy_q[(k == 0) ? 0 : k - 1];
      vld_d[k] = (k == 0) ? in_valid : vld_q[(k == 0) ? 0 : k - 1];
      tag_d[k] = (k == 0) ? in_tag : tag_q[(k == 0) ? 0 : k - 1];
      {cy_d[k], seg_s[k]} = {1'b0, a_s[k][k*SEG_WIDTH +: SEG_WIDTH]}
                          + {1'b0, b_s[k][k*SEG_WIDTH +: SEG_WIDTH]}
                          + {{SEG_WIDTH{1'b0}}, ci_s[k]};
      res_d[k] = a_s[k];
      res_d[k][k*SEG_WIDTH +: SEG_WIDTH] = seg_s[k];
    end
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_q <= '0;
      res_q <= '0;
      b_q   <= '0;
      cy_q  <= '0;
      tag_q <= '0;
    end else if (advance) begin
      vld_q <= vld_d;
      res_q <= res_d;
      b_q   <= b_s;
      cy_q  <= cy_d;
      tag_q <= tag_d;
    end
  end
endmodule

// File: tb/tb_mul_cpa_pipe.sv
// tb_mul_cpa_pipe: directed self-checking bench for mul_cpa_pipe
module tb_mul_cpa_pipe;
  logic         clock = 1'b0;
  logic         reset_n;
  logic         in_valid, in_ready, out_valid, out_ready, out_carry;
  logic [127:0] in_cout, in_sout, out_sum;
  logic [3:0]   in_tag, out_tag;
  int           n_cmp = 0, n_bad = 0;
  logic [127:0] op_s[16], op_c[16], op_es[16];
  logic         op_ec[16];
  logic [3:0]   op_t[16];
  int           first_pop, last_pop, n_pop;

  always #5 clock = ~clock;

  mul_cpa_pipe dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_cout(in_cout), .in_sout(in_sout), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_carry(out_carry), .out_tag(out_tag)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [128:0] ref_add(input logic [127:0] s, input logic [127:0] c);
    logic [127:0] b;
    b = c << 1;
    return {1'b0, s} + {1'b0, b};
  endfunction

  task automatic load(input int i, input logic [127:0] s, input logic [127:0] c, input logic [3:0] t,
                      input logic [127:0] es, input logic ec);
    op_s[i] = s; op_c[i] = c; op_t[i] = t; op_es[i] = es; op_ec[i] = ec;
  endtask

  task automatic load_ref(input int i, input logic [127:0] s, input logic [127:0] c, input logic [3:0] t);
    logic [128:0] r;
    r = ref_add(s, c);
    load(i, s, c, t, r[127:0], r[128]);
  endtask

  // Runs n ops through the DUT with out_ready low during cycles lo..hi; cycle 0 drives the first op.
  task automatic run_stream(input int n, input int lo, input int hi);
    int q[$];
    int idx, cyc, j;
    logic         held_ok;
    logic [127:0] held_sum;
    logic [3:0]   held_tag;
    idx = 0; cyc = 0; held_ok = 0; first_pop = -1; last_pop = -1; n_pop = 0;
    while ((idx < n || q.size() > 0) && cyc < 200) begin
      out_ready = !(cyc >= lo && cyc <= hi);
      in_valid  = idx < n;
      if (idx < n) begin
        in_sout = op_s[idx]; in_cout = op_c[idx]; in_tag = op_t[idx];
      end
      #1;
      if (out_valid && !out_ready) begin
        chk("stall_in_ready", in_ready, 0);
        if (held_ok) begin
          chk("stall_sum_hold", out_sum, held_sum);
          chk("stall_tag_hold", out_tag, held_tag);
        end
        held_ok = 1; held_sum = out_sum; held_tag = out_tag;
      end else held_ok = 0;
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("spurious_out", 1, 0);
        else begin
          j = q.pop_front();
          chk("sum", out_sum, op_es[j]);
          chk("carry", out_carry, op_ec[j]);
          chk("tag", out_tag, op_t[j]);
        end
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
        n_pop++;
      end
      if (in_valid && in_ready) begin
        q.push_back(idx);
        idx++;
      end
      @(posedge clock); #1;
      cyc++;
    end
    in_valid = 0; out_ready = 1;
    chk("stream_done", cyc < 200, 1);
    chk("pop_count", n_pop, n);
  endtask

  initial begin
    reset_n = 0; in_valid = 0; out_ready = 1; in_cout = '0; in_sout = '0; in_tag = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_out_carry", out_carry, 0);
    chk("rst_out_tag", out_tag, 0);
    reset_n = 1;
    @(posedge clock); #1;
    chk("rst_in_ready", in_ready, 1);

    load(0, 128'h5, 128'h3, 4'hA, 128'hB, 1'b0);
    run_stream(1, 1000, 1000);
    chk("single_latency", first_pop, 4);

    load(0, {128{1'b1}}, 128'h0, 4'h1, {128{1'b1}}, 1'b0);
    load(1, {{127{1'b1}}, 1'b0}, 128'h1, 4'h2, 128'h0, 1'b1);
    load(2, 128'h0, 128'h1 << 127, 4'h3, 128'h0, 1'b0);
    load(3, 128'h1 << 127, 128'h1 << 126, 4'h4, 128'h0, 1'b1);
    load(4, 128'h0000_0000_ffff_ffff_0000_0000_ffff_ffff, 128'h0000_0000_0000_0000_0000_0000_0000_0001,
         4'h5, 128'h0000_0000_ffff_ffff_0000_0001_0000_0001, 1'b0);
    run_stream(5, 1000, 1000);

    load_ref(0, 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210, 128'h1111_2222_3333_4444_5555_6666_7777_8888, 4'd0);
    load_ref(1, 128'hffff_ffff_0000_0000_ffff_ffff_0000_0000, 128'h8000_0000_8000_0000_8000_0000_8000_0000, 4'd1);
    load_ref(2, 128'hdead_beef_cafe_babe_0bad_f00d_1234_5678, 128'hfeed_face_0000_0001_dead_0000_ffff_0001, 4'd2);
    load_ref(3, 128'h7fff_ffff_ffff_ffff_ffff_ffff_ffff_ffff, 128'h4000_0000_0000_0000_0000_0000_0000_0000, 4'd3);
    load_ref(4, 128'h0000_0001_0000_0002_0000_0003_0000_0004, 128'hffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff, 4'd4);
    load_ref(5, 128'h5555_5555_aaaa_aaaa_5555_5555_aaaa_aaaa, 128'h2aaa_aaaa_d555_5555_2aaa_aaaa_d555_5555, 4'd5);
    load_ref(6, 128'h8000_0000_0000_0000_0000_0000_0000_0000, 128'hc000_0000_0000_0000_0000_0000_0000_0000, 4'd6);
    load_ref(7, 128'h0f0f_0f0f_f0f0_f0f0_3c3c_3c3c_c3c3_c3c3, 128'h0707_0707_7878_7878_1e1e_1e1e_6161_6161, 4'd7);
    run_stream(8, 1000, 1000);
    chk("stream_first", first_pop, 4);
    chk("stream_last", last_pop, 11);

    for (int i = 0; i < 6; i++)
      load_ref(i, op_s[i] ^ op_s[7 - i], op_c[7 - i], 4'(9 + i));
    run_stream(6, 5, 9);
    chk("bp_last_after_stall", last_pop > 9, 1);

    for (int i = 0; i < 3; i++) begin
      in_valid = 1; in_sout = 128'(i + 1); in_cout = 128'(i + 7); in_tag = 4'(i + 1);
      #1;
      chk("mid_in_ready", in_ready, 1);
      @(posedge clock); #1;
    end
    in_valid = 0;
    reset_n = 0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_sum", out_sum, 0);
    chk("midrst_out_carry", out_carry, 0);
    chk("midrst_out_tag", out_tag, 0);
    @(posedge clock); #1;
    reset_n = 1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clock); #1;
      chk("midrst_no_valid", out_valid, 0);
    end
    load(0, 128'h10, 128'h8, 4'hC, 128'h20, 1'b0);
    run_stream(1, 1000, 1000);
    chk("midrst_new_latency", first_pop, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mul_cpa_pipe.md
Name: mul_cpa_pipe

Overview:
- Final carry-propagate adder stage of the integer multiplier.
- Consumes the redundant carry/sum vectors produced by the 33-input Wallace-tree compressor and resolves them into a binary result.
- Uses a segmented, pipelined ripple adder with a valid/ready handshake and a tag sideband, so the multiplier can stall against downstream back-pressure.

Parameters:
- DATA_WIDTH, 128, width of the carry/sum vectors and the result.
- SEG_WIDTH, 32, bits resolved per pipeline stage; DATA_WIDTH must be a multiple of SEG_WIDTH; NSEG = DATA_WIDTH/SEG_WIDTH.
- TAG_WIDTH, 4, width of the opaque sideband tag carried alongside each operation.

Ports:
- clock  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_cout/in_sout/in_tag valid this cycle.
- in_ready  output  1  stage accepts input this cycle.
- in_cout  input  DATA_WIDTH  compressor carry vector; bit j has weight 2^(j+1).
- in_sout  input  DATA_WIDTH  compressor sum vector; bit j has weight 2^j.
- in_tag  input  TAG_WIDTH  sideband, returned unchanged with the result.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out_sum  output  DATA_WIDTH  (in_sout + (in_cout << 1)) mod 2^DATA_WIDTH.
- out_carry  output  1  carry out of bit DATA_WIDTH-1 of that addition, taken after dropping in_cout[DATA_WIDTH-1].
- out_tag  output  TAG_WIDTH  tag of the result.

Behaviour:
- Reset (asynchronous on reset_n=0):
  - all stage valid bits, out_valid, out_sum, out_carry, out_tag and internal data/carry registers = 0;
  - in_ready = 1 from the first cycle after reset release.
- Operand prep (combinational on input): A = in_sout, B = {in_cout[DATA_WIDTH-2:0], 1'b0}. in_cout[DATA_WIDTH-1] is discarded.
- Pipeline: NSEG register stages; stage k (k = 0..NSEG-1) performs one SEG_WIDTH ripple add of segment k of A and B plus the carry registered by stage k-1 (stage 0 carry-in = 0).
- Data movement: resolved low segments and unresolved high operand segments shift forward with each stage. Tag and valid travel with the data.
- Latency: NSEG cycles from input acceptance to out_valid, assuming no stall (4 at defaults).
- Global stall: advance = !out_valid | out_ready; in_ready = advance.
  - When advance=0, every stage register holds and the outputs stay stable.
  - When advance=1, all stages shift by one; a bubble (valid=0) shifts like data.
- Handshake:
  - Input is accepted iff in_valid & in_ready.
  - Output is transferred iff out_valid & out_ready.
  - out_sum/out_carry/out_tag must not change while out_valid=1 & out_ready=0.
- Throughput: one operation per cycle while out_ready=1. Back-to-back operations stay in order and never merge.
- Simultaneous output transfer and input acceptance in the same cycle is legal and loses nothing.
- Input presented while in_ready=0 is ignored; the source must hold it.
- Invalid stages may hold stale data; out_sum is only meaningful when out_valid=1.
- Wrap-around: results are mod 2^DATA_WIDTH and out_carry reports the overflow. For example, all-ones + 1 gives out_sum=0, out_carry=1.
- Reset mid-operation: all in-flight operations are discarded; no out_valid is asserted for them after reset release.
- Datapath registers are plain enables; only the valid bits require the reset for functional correctness, but all registers reset to 0 anyway.

Test Plan:
- Single op, out_ready=1: in_sout=0x5, in_cout=0x3 -> after 4 cycles out_valid=1, out_sum=0xB, out_carry=0, out_tag echoes in_tag=0xA.
- Carry across every segment: in_sout=2^128-1, in_cout=0 plus a second op in_sout=2^128-2, in_cout=1 -> first out_sum=2^128-1, carry=0; second out_sum=0, carry=1.
- Dropped top carry bit: in_cout=2^127, in_sout=0 -> out_sum=0, out_carry=0.
- Back-to-back streaming of 8 random ops with tags 0..7 and out_ready=1 -> 8 consecutive out_valid cycles starting at cycle 4, tags in order, each sum matching the reference model.
- Back-pressure:
  - Stream 6 ops, hold out_ready=0 for cycles 5..9.
  - Required response: in_ready=0 during the stall, out_sum/out_tag stable, no op lost or duplicated, all 6 results delivered in order once out_ready=1.
- Reset mid-flight: 3 ops accepted, then reset_n=0 for 1 cycle -> all outputs 0 immediately, no out_valid for those ops afterwards, and a new op after release completes with latency 4.
